// File: rtl/mips_main_ctrl.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects, write enables and the registered ALU op.
module mips_main_ctrl #(
    parameter int unsigned OPC_W = 6,
    parameter int unsigned ST_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_source,
    output logic [2:0]       alu_op,
    output logic             instr_done,
    output logic             illegal,
    output logic [ST_W-1:0]  state
);

    localparam logic [OPC_W-1:0] OP_R    = OPC_W'(6'h00);
    localparam logic [OPC_W-1:0] OP_J    = OPC_W'(6'h02);
    localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(6'h04);
    localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(6'h08);
    localparam logic [OPC_W-1:0] OP_ANDI = OPC_W'(6'h0C);
    localparam logic [OPC_W-1:0] OP_ORI  = OPC_W'(6'h0D);
    localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(6'h23);
    localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(6'h2B);

    localparam logic [2:0] ALU_FUNCT = 3'd0;
    localparam logic [2:0] ALU_ADD   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_SUB   = 3'd4;

    typedef enum logic [ST_W-1:0] {
        S_FETCH  = ST_W'(0),
        S_DECODE = ST_W'(1),
        S_MEMADR = ST_W'(2),
        S_MEMRD  = ST_W'(3),
        S_MEMWB  = ST_W'(4),
        S_MEMWR  = ST_W'(5),
        S_EXEC   = ST_W'(6),
        S_RWB    = ST_W'(7),
        S_BRANCH = ST_W'(8),
        S_JUMP   = ST_W'(9),
        S_IEXEC  = ST_W'(10),
        S_IWB    = ST_W'(11)
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] alu_op_q, alu_op_d;

    // The branch decision on zero is made in the datapath via pc_write_cond.
    logic unused_zero;
    assign unused_zero = zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            alu_op_q <= ALU_ADD;
        end else begin
            state_q  <= state_d;
            alu_op_q <= alu_op_d;
        end
    end

    assign state  = state_q;
    assign alu_op = alu_op_q;

    // Next state and Moore outputs; reset masks every enable and pulse.
    always_comb begin
        state_d       = S_FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        instr_done    = 1'b0;
        illegal       = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                state_d   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW:               state_d = S_MEMADR;
                    OP_R:                       state_d = S_EXEC;
                    OP_BEQ:                     state_d = S_BRANCH;
                    OP_J:                       state_d = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI:   state_d = S_IEXEC;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                state_d  = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
                state_d    = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                state_d   = S_RWB;
            end
            S_RWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_IWB;
            end
            S_IWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        if (reset) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            mem_write     = 1'b0;
            mem_read      = 1'b0;
            instr_done    = 1'b0;
            illegal       = 1'b0;
        end
    end

    // ALU op is picked for the state being entered so it lines up with it.
    always_comb begin
        alu_op_d = ALU_ADD;
        case (state_d)
            S_EXEC:   alu_op_d = ALU_FUNCT;
            S_BRANCH: alu_op_d = ALU_SUB;
            S_IEXEC: begin
                case (opcode)
                    OP_ANDI: alu_op_d = ALU_AND;
                    OP_ORI:  alu_op_d = ALU_OR;
                    default: alu_op_d = ALU_ADD;
                endcase
            end
            default:  alu_op_d = ALU_ADD;
        endcase
    end

endmodule

// File: tb/tb_mips_main_ctrl.sv
// Scoreboard bench for mips_main_ctrl: per-cycle directed vectors queue expected
// state/alu_op/control words; a negedge monitor pops and compares.
module tb_mips_main_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic       instr_done, illegal;
    logic [3:0] state;

    always #5 clk = ~clk;

    mips_main_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
        .alu_op(alu_op), .instr_done(instr_done), .illegal(illegal), .state(state)
    );

    // ctl bits: 15 pc_write, 14 pc_write_cond, 13 iord, 12 mem_read, 11 mem_write,
    // 10 ir_write, 9 mem_to_reg, 8 reg_dst, 7 reg_write, 6 alu_src_a,
    // 5:4 alu_src_b, 3:2 pc_source, 1 instr_done, 0 illegal
    localparam logic [15:0] C_FETCH   = 16'h9410;
    localparam logic [15:0] C_FETCHST = 16'h1010;
    localparam logic [15:0] C_DECODE  = 16'h0030;
    localparam logic [15:0] C_DECILL  = 16'h0031;
    localparam logic [15:0] C_MEMADR  = 16'h0060;
    localparam logic [15:0] C_MEMRD   = 16'h3000;
    localparam logic [15:0] C_MEMWB   = 16'h0282;
    localparam logic [15:0] C_MEMWR   = 16'h2802;
    localparam logic [15:0] C_MEMWRST = 16'h2800;
    localparam logic [15:0] C_EXEC    = 16'h0040;
    localparam logic [15:0] C_RWB     = 16'h0182;
    localparam logic [15:0] C_BRANCH  = 16'h4046;
    localparam logic [15:0] C_JUMP    = 16'h800A;
    localparam logic [15:0] C_IEXEC   = 16'h0060;
    localparam logic [15:0] C_IWB     = 16'h0082;
    localparam logic [15:0] M_ALL     = 16'hFFFF;
    localparam logic [15:0] M_ENABLES = 16'hDC83;

    typedef struct packed {
        logic        chk_st;
        logic [3:0]  st;
        logic [2:0]  aop;
        logic [15:0] ctl;
        logic [15:0] msk;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    function automatic logic [15:0] ctl_word();
        return {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
                instr_done, illegal};
    endfunction

    // Monitor: the DUT presents a control word every cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [15:0] act;
            e = q.pop_front();
            act = ctl_word();
            total++;
            if ((act & e.msk) !== (e.ctl & e.msk)) begin
                bad++;
                $display("FAIL ctl t=%0t got=%h want=%h mask=%h", $time, act, e.ctl, e.msk);
            end
            if (e.chk_st) begin
                total++;
                if (state !== e.st) begin
                    bad++;
                    $display("FAIL state t=%0t got=%0d want=%0d", $time, state, e.st);
                end
                total++;
                if (alu_op !== e.aop) begin
                    bad++;
                    $display("FAIL alu_op t=%0t got=%0d want=%0d", $time, alu_op, e.aop);
                end
            end
        end
    end

    task automatic cyc(input logic rst, input logic [5:0] opc, input logic mr,
                       input logic z, input logic [3:0] st, input logic [2:0] aop,
                       input logic [15:0] ctl);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst;
        opcode = opc;
        mem_ready = mr;
        zero = z;
        e.chk_st = ~rst;
        e.st = st;
        e.aop = aop;
        e.ctl = ctl;
        e.msk = rst ? M_ENABLES : M_ALL;
        q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // reset: all enables low
        cyc(1, 6'h23, 1, 0, 0, 1, 16'h0000);
        cyc(1, 6'h23, 1, 0, 0, 1, 16'h0000);
        // lw, no stalls
        cyc(0, 6'h23, 1, 0, 0, 1, C_FETCH);
        cyc(0, 6'h23, 1, 0, 1, 1, C_DECODE);
        cyc(0, 6'h23, 1, 0, 2, 1, C_MEMADR);
        cyc(0, 6'h23, 1, 0, 3, 1, C_MEMRD);
        cyc(0, 6'h23, 1, 0, 4, 1, C_MEMWB);
        // R-type
        cyc(0, 6'h00, 1, 0, 0, 1, C_FETCH);
        cyc(0, 6'h00, 1, 0, 1, 1, C_DECODE);
        cyc(0, 6'h00, 1, 0, 6, 0, C_EXEC);
        cyc(0, 6'h00, 1, 0, 7, 1, C_RWB);
        // beq taken, then not taken
        cyc(0, 6'h04, 1, 1, 0, 1, C_FETCH);
        cyc(0, 6'h04, 1, 1, 1, 1, C_DECODE);
        cyc(0, 6'h04, 1, 1, 8, 4, C_BRANCH);
        cyc(0, 6'h04, 1, 0, 0, 1, C_FETCH);
        cyc(0, 6'h04, 1, 0, 1, 1, C_DECODE);
        cyc(0, 6'h04, 1, 0, 8, 4, C_BRANCH);
        // ori with three FETCH stall cycles
        cyc(0, 6'h0D, 0, 0, 0, 1, C_FETCHST);
        cyc(0, 6'h0D, 0, 0, 0, 1, C_FETCHST);
        cyc(0, 6'h0D, 0, 0, 0, 1, C_FETCHST);
        cyc(0, 6'h0D, 1, 0, 0, 1, C_FETCH);
        cyc(0, 6'h0D, 1, 0, 1, 1, C_DECODE);
        cyc(0, 6'h0D, 1, 0, 10, 3, C_IEXEC);
        cyc(0, 6'h0D, 1, 0, 11, 1, C_IWB);
        // addi and andi
        cyc(0, 6'h08, 1, 0, 0, 1, C_FETCH);
        cyc(0, 6'h08, 1, 0, 1, 1, C_DECODE);
        cyc(0, 6'h08, 1, 0, 10, 1, C_IEXEC);
        cyc(0, 6'h08, 1, 0, 11, 1, C_IWB);
        cyc(0, 6'h0C, 1, 0, 0, 1, C_FETCH);
        cyc(0, 6'h0C, 1, 0, 1, 1, C_DECODE);
        cyc(0, 6'h0C, 1, 0, 10, 2, C_IEXEC);
        cyc(0, 6'h0C, 1, 0, 11, 1, C_IWB);
        // jump
        cyc(0, 6'h02, 1, 0, 0, 1, C_FETCH);
        cyc(0, 6'h02, 1, 0, 1, 1, C_DECODE);
        cyc(0, 6'h02, 1, 0, 9, 1, C_JUMP);
        // sw with two MEMWR stall cycles
        cyc(0, 6'h2B, 1, 0, 0, 1, C_FETCH);
        cyc(0, 6'h2B, 1, 0, 1, 1, C_DECODE);
        cyc(0, 6'h2B, 1, 0, 2, 1, C_MEMADR);
        cyc(0, 6'h2B, 0, 0, 5, 1, C_MEMWRST);
        cyc(0, 6'h2B, 0, 0, 5, 1, C_MEMWRST);
        cyc(0, 6'h2B, 1, 0, 5, 1, C_MEMWR);
        // illegal opcode
        cyc(0, 6'h3F, 1, 0, 0, 1, C_FETCH);
        cyc(0, 6'h3F, 1, 0, 1, 1, C_DECODE | C_DECILL);
        cyc(0, 6'h3F, 1, 0, 0, 1, C_FETCH);
        // lw, reset during a MEMRD stall
        cyc(0, 6'h23, 1, 0, 1, 1, C_DECODE);
        cyc(0, 6'h23, 0, 0, 2, 1, C_MEMADR);
        cyc(0, 6'h23, 0, 0, 3, 1, C_MEMRD);
        cyc(1, 6'h23, 0, 0, 3, 1, 16'h0000);
        cyc(0, 6'h23, 1, 0, 0, 1, C_FETCH);
        cyc(0, 6'h23, 1, 0, 1, 1, C_DECODE);
        @(posedge clk);
        @(posedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_main_ctrl.md
Name: mips_main_ctrl

Overview:
- Multicycle MIPS main control FSM; sits directly upstream of the ALU control decoder and produces its 3-bit alu_op.
- Decodes the instruction opcode and sequences the datapath through fetch, decode, execute, memory and writeback.
- Drives the datapath mux selects and write enables, and stalls on memory handshake.

Parameters:
- OPC_W, 6, opcode width
- ST_W, 4, state register width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26], stable from DECODE until the next FETCH
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if zero
- iord  out  1  memory address: 0=PC, 1=ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load
- mem_to_reg  out  1  writeback source: 1=MDR
- reg_dst  out  1  destination: 1=rd, 0=rt
- reg_write  out  1  register file write
- alu_src_a  out  1  0=PC, 1=rs
- alu_src_b  out  2  00=rt, 01=4, 10=sign-ext imm, 11=imm<<2
- pc_source  out  2  00=ALU, 01=ALUOut, 10=jump target
- alu_op  out  3  to ALU control: 0=use funct, 1=add, 2=and, 3=or, 4=sub
- instr_done  out  1  one-cycle pulse on an instruction's last cycle
- illegal  out  1  one-cycle pulse for an unsupported opcode
- state  out  4  current state, for debug

Behaviour:
- Opcodes: R=0x00, lw=0x23, sw=0x2B, beq=0x04, j=0x02, addi=0x08, andi=0x0C, ori=0x0D.
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11.
- Transitions:
  - FETCH->DECODE when mem_ready; otherwise stay.
  - DECODE->MEMADR for lw/sw; EXEC for R; BRANCH for beq; JUMP for j; IEXEC for addi/andi/ori.
  - DECODE, illegal opcode: pulse illegal and go to FETCH.
  - MEMADR->MEMRD for lw, MEMWR for sw.
  - MEMRD->MEMWB when mem_ready. MEMWR->FETCH when mem_ready.
  - EXEC->RWB. IEXEC->IWB.
  - MEMWB, RWB, IWB, BRANCH, JUMP -> FETCH.
- Moore outputs, decoded from state; unlisted outputs are 0.
  - FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, pc_source=00; ir_write=pc_write=mem_ready.
  - DECODE: alu_src_a=0, alu_src_b=11.
  - MEMADR: alu_src_a=1, alu_src_b=10.
  - MEMRD: mem_read=1, iord=1.
  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0.
  - MEMWR: mem_write=1, iord=1, held until mem_ready.
  - EXEC: alu_src_a=1, alu_src_b=00.
  - RWB: reg_write=1, reg_dst=1, mem_to_reg=0.
  - BRANCH: alu_src_a=1, alu_src_b=00, pc_write_cond=1, pc_source=01.
  - JUMP: pc_write=1, pc_source=10.
  - IEXEC: alu_src_a=1, alu_src_b=10.
  - IWB: reg_write=1, reg_dst=0, mem_to_reg=0.
- alu_op is registered and carries the op for the state being entered, so the registered ALU control output is aligned with that state.
  - Next state EXEC -> 0.
  - Next state BRANCH -> 4.
  - Next state IEXEC -> 1 for addi, 2 for andi, 3 for ori.
  - All other next states -> 1.
- instr_done is high in MEMWB, MEMWR (when mem_ready), RWB, IWB, BRANCH and JUMP.
- Cycle counts with mem_ready=1: lw 5, sw 4, R 4, addi/andi/ori 4, beq 3, j 3. Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Reset:
  - While reset=1, pc_write, pc_write_cond, ir_write, reg_write, mem_write and mem_read are forced to 0, and instr_done/illegal are forced to 0.
  - At the next edge: state=FETCH, alu_op=1.
  - Reset takes priority mid-stall; a pending memory access is abandoned.
- Unused state encodings (12-15) go to FETCH on the next edge with all enables 0.

Test Plan:
- Reset, then opcode=0x23, mem_ready=1 -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 in cycle 5 only; alu_op=1 throughout.
- opcode=0x00 -> states 0,1,6,7; alu_op=0 during EXEC, =1 otherwise; reg_dst=1 and instr_done in RWB.
- opcode=0x04, zero=1, then zero=0 -> BRANCH reached in cycle 3 both times with alu_op=4 and pc_write_cond=1; pc_write=0 in BRANCH.
- opcode=0x0D with mem_ready=0 for 3 FETCH cycles -> FETCH held 4 cycles, ir_write only on the 4th; IEXEC alu_op=3; total 7 cycles.
- opcode=0x2B, mem_ready low 2 cycles in MEMWR -> mem_write high 3 cycles; instr_done only on the last of them.
- opcode=0x3F -> illegal pulse in DECODE, back to FETCH. reset asserted during a MEMRD stall -> all enables 0 that cycle; FETCH with alu_op=1 next.
